// File: rtl/fpu_pkg.sv
// Shared FPU definitions: canonical constants, flag positions, operand
// classes and the front-end controller state encoding.
package fpu_pkg;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int unsigned NV = 4;
  localparam int unsigned DZ = 3;
  localparam int unsigned OF = 2;
  localparam int unsigned UF = 1;
  localparam int unsigned NX = 0;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_t;

  // Controller states kept as plain constants for legacy compatibility
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/fp_classify.sv
// Combinational single-precision operand classifier (sign + class).
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] a,
  output logic        sign,
  output fp_class_t   cls
);

  logic [7:0]  exp_f;
  logic [22:0] mant_f;

  assign sign   = a[31];
  assign exp_f  = a[30:23];
  assign mant_f = a[22:0];

  // Decode exponent/mantissa into an operand class
  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = (mant_f == '0) ? ZERO : DENORM;
    end else if (exp_f == '1) begin
      if (mant_f == '0)
        cls = INF;
      else if (mant_f[22])
        cls = QNAN;
      else
        cls = SNAN;
    end
  end

endmodule

// File: rtl/fsqrt_ctrl.sv
// FSQRT.S front-end: classifies the operand, resolves special cases
// locally and sequences the combinational sqrt core for positive normals.
module fsqrt_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned CORE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] core_a,
  input  logic [31:0] core_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             a_sign;
  fp_class_t        a_cls;

  fp_classify u_classify (
    .a    (a),
    .sign (a_sign),
    .cls  (a_cls)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // FSM, settle counter and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      core_a <= '0;
      result <= '0;
      fflags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // NaN classes are tested before the sign so -NaN is not flagged
            // as a negative operand
            if (a_cls == QNAN) begin
              result <= CANON_NAN;
              fflags <= '0;
              state  <= DONE;
            end else if (a_cls == SNAN) begin
              result     <= CANON_NAN;
              fflags     <= '0;
              fflags[NV] <= 1'b1;
              state      <= DONE;
            end else if (a_sign && (a_cls != ZERO)) begin
              result     <= CANON_NAN;
              fflags     <= '0;
              fflags[NV] <= 1'b1;
              state      <= DONE;
            end else begin
              case (a_cls)
                ZERO: begin
                  result <= a;
                  fflags <= '0;
                  state  <= DONE;
                end
                INF: begin
                  result <= POS_INF;
                  fflags <= '0;
                  state  <= DONE;
                end
                DENORM: begin
                  result <= '0;
                  fflags <= '0;
                  state  <= DONE;
                end
                default: begin
                  core_a <= a;
                  cnt    <= CNT_W'(CORE_LATENCY - 1);
                  state  <= WAIT;
                end
              endcase
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            result <= core_result;
            fflags <= '0;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsqrt_ctrl.sv
// Directed bench for fsqrt_ctrl: one instance at CORE_LATENCY=4, one at 1.
module tb_fsqrt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = '0;

  logic        start4, busy4, done4;
  logic [31:0] a4, core_a4, core_res4, result4;
  logic [4:0]  fflags4;

  logic        start1, busy1, done1;
  logic [31:0] a1, core_a1, core_res1, result1;
  logic [4:0]  fflags1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub for the latency-1 instance changes every cycle
  assign core_res1 = {16'h3F80, cyc[15:0]};

  fsqrt_ctrl #(.CORE_LATENCY(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .a           (a4),
    .core_a      (core_a4),
    .core_result (core_res4),
    .busy        (busy4),
    .done        (done4),
    .result      (result4),
    .fflags      (fflags4)
  );

  fsqrt_ctrl #(.CORE_LATENCY(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start       (start1),
    .a           (a1),
    .core_a      (core_a1),
    .core_result (core_res1),
    .busy        (busy1),
    .done        (done1),
    .result      (result1),
    .fflags      (fflags1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one special operand to dut4 from an IDLE negedge
  task automatic run_special(input string tag, input logic [31:0] av,
                             input logic [31:0] exp_res, input logic [4:0] exp_fl);
    logic [31:0] prev_core_a;
    prev_core_a = core_a4;
    a4     = av;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check({tag, "_done"},   32'(done4),   32'd1);
    check({tag, "_result"}, result4,      exp_res);
    check({tag, "_fflags"}, 32'(fflags4), 32'(exp_fl));
    check({tag, "_core_a"}, core_a4,      prev_core_a);
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done4), 32'd0);
    check({tag, "_idle"},     32'(busy4), 32'd0);
  endtask

  initial begin
    int unsigned npulse;
    logic [31:0] c0;

    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    a4 = '0; a1 = '0; core_res4 = 32'h4000_0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",   32'(busy4),   32'd0);
    check("rst_done",   32'(done4),   32'd0);
    check("rst_core_a", core_a4,      32'd0);
    check("rst_result", result4,      32'd0);
    check("rst_fflags", 32'(fflags4), 32'd0);

    // 1: sqrt(4.0), latency 4
    a4 = 32'h4080_0000; start4 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      check($sformatf("n_busy_c%0d", k), 32'(busy4), 32'(k <= 5));
      check($sformatf("n_done_c%0d", k), 32'(done4), 32'(k == 5));
      if (k <= 5) check($sformatf("n_core_a_c%0d", k), core_a4, 32'h4080_0000);
      if (k == 2) check("n_result_wait", result4, 32'd0);
      if (k == 5) begin
        check("n_result", result4,      32'h4000_0000);
        check("n_fflags", 32'(fflags4), 32'd0);
      end
    end

    // 2, 3: special operands
    run_special("neg1",   32'hBF80_0000, 32'h7FC0_0000, 5'h10);
    run_special("neginf", 32'hFF80_0000, 32'h7FC0_0000, 5'h10);
    run_special("snan",   32'h7F80_0001, 32'h7FC0_0000, 5'h10);
    run_special("qnan",   32'hFFC0_0000, 32'h7FC0_0000, 5'h00);
    run_special("negz",   32'h8000_0000, 32'h8000_0000, 5'h00);
    run_special("denorm", 32'h0000_0001, 32'h0000_0000, 5'h00);
    run_special("posinf", 32'h7F80_0000, 32'h7F80_0000, 5'h00);
    run_special("posz",   32'h0000_0000, 32'h0000_0000, 5'h00);

    // 4: start while busy is dropped; re-accept right after DONE
    core_res4 = 32'h4000_0000;
    a4 = 32'h4080_0000; start4 = 1'b1;
    npulse = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) npulse++;
      if (k == 2) begin a4 = 32'h4110_0000; start4 = 1'b1; end
      if (k <= 5) check($sformatf("busy_core_a_c%0d", k), core_a4, 32'h4080_0000);
      if (k == 5) check("busy_result", result4, 32'h4000_0000);
    end
    check("busy_pulses", npulse, 32'd1);
    check("reaccept_idle", 32'(busy4), 32'd0);
    core_res4 = 32'h4040_0000;
    a4 = 32'h4110_0000; start4 = 1'b1;
    npulse = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) npulse++;
    end
    check("reaccept_pulses", npulse,  32'd1);
    check("reaccept_done",   32'(done4), 32'd1);
    check("reaccept_result", result4, 32'h4040_0000);
    check("reaccept_core_a", core_a4, 32'h4110_0000);
    @(negedge clk);

    // 5: reset during WAIT
    core_res4 = 32'h4000_0000;
    a4 = 32'h4080_0000; start4 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start4 = 1'b0;
    end
    check("pre_rst_busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy",   32'(busy4),   32'd0);
    check("mid_rst_done",   32'(done4),   32'd0);
    check("mid_rst_result", result4,      32'd0);
    check("mid_rst_fflags", 32'(fflags4), 32'd0);
    npulse = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done4) npulse++;
    end
    check("mid_rst_no_done", npulse, 32'd0);

    // 6: latency 1, back-to-back, core output changing every cycle
    for (int r = 0; r < 3; r++) begin
      a1 = 32'h4080_0000 + 32'(r << 20); start1 = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start1 = 1'b0;
      check($sformatf("l1_busy_r%0d", r), 32'(busy1), 32'd1);
      check($sformatf("l1_wait_r%0d", r), 32'(done1), 32'd0);
      @(negedge clk);
      check($sformatf("l1_done_r%0d", r),   32'(done1), 32'd1);
      check($sformatf("l1_result_r%0d", r), result1, {16'h3F80, 16'(c0 + 1)});
      check($sformatf("l1_fflags_r%0d", r), 32'(fflags1), 32'd0);
      @(negedge clk);
      check($sformatf("l1_idle_r%0d", r), 32'(busy1), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
